// File: rtl/aes_cmd_seq.sv
// aes_cmd_seq: command sequencer in front of aes_top.
//
// Accepts key-load / encrypt commands over a valid/ready handshake, holds the
// key and plaintext operands stable, pulses aes_en with the matching ctrl code,
// waits for aes_en_o (bounded by a watchdog), checks the status bit for the op,
// and returns ciphertext or an error code over a valid/ready response channel.
// Tracks whether a valid expanded key is resident (key_loaded).
//
// Ports:
//   clk, reset            single clock, synchronous active-high reset
//   cmd_valid/cmd_ready   command handshake; cmd_op 0=key load, 1=encrypt
//   cmd_data              key (key load) or plaintext in [0:BLK_S-1] (encrypt)
//   rsp_valid/rsp_ready   response handshake
//   rsp_data, rsp_err     ciphertext / error (00 OK, 01 NOKEY, 10 TIMEOUT, 11 STATUS)
//   key_loaded            expanded key resident and valid
//   aes_en, aes_ctrl      one-cycle start pulse and op code to aes_top
//   aes_key, aes_plaintext registered operands to aes_top
//   aes_en_o, aes_status, aes_ciphertext  completion, status and result from aes_top
//
// Width/code macros normally come from aes.vh; fallback values are provided
// here so the block builds stand-alone.

`ifndef KEY_S
`define KEY_S 128
`endif
`ifndef BLK_S
`define BLK_S 128
`endif
`ifndef CTRL_S
`define CTRL_S 2
`endif
`ifndef STATUS_S
`define STATUS_S 4
`endif
`ifndef CTRL_KEY
`define CTRL_KEY 2'b01
`endif
`ifndef CTRL_ENCRYPT
`define CTRL_ENCRYPT 2'b10
`endif
`ifndef S_KEY_MASK
`define S_KEY_MASK 4'b0001
`endif
`ifndef S_CIPHER_MASK
`define S_CIPHER_MASK 4'b0010
`endif

module aes_cmd_seq #(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   cmd_valid,
  output logic                   cmd_ready,
  input  logic                   cmd_op,
  input  logic [0:`KEY_S-1]      cmd_data,
  output logic                   rsp_valid,
  input  logic                   rsp_ready,
  output logic [0:`BLK_S-1]      rsp_data,
  output logic [1:0]             rsp_err,
  output logic                   key_loaded,
  output logic                   aes_en,
  output logic [`CTRL_S-1:0]     aes_ctrl,
  output logic [0:`KEY_S-1]      aes_key,
  output logic [0:`BLK_S-1]      aes_plaintext,
  input  logic                   aes_en_o,
  input  logic [`STATUS_S-1:0]   aes_status,
  input  logic [0:`BLK_S-1]      aes_ciphertext
);

  typedef enum logic [1:0] {IDLE, START, WAIT, RESP} state_t;

  state_t      state, state_nxt;
  logic        op;
  logic [15:0] cnt;
  logic        accept, nokey, done, tmo, status_ok;

  always_comb begin
    state_nxt = state;
    accept    = (state == IDLE) && cmd_valid;
    nokey     = accept && cmd_op && !key_loaded;
    status_ok = op ? |(aes_status & `S_CIPHER_MASK) : |(aes_status & `S_KEY_MASK);
    done      = (state == WAIT) && aes_en_o;
    // cnt counts WAIT cycles already elapsed, so this is the TIMEOUT_CYCLES-th
    // WAIT cycle; completion in the same cycle takes priority.
    tmo       = (state == WAIT) && !aes_en_o && ((cnt + 16'd1) == 16'(TIMEOUT_CYCLES));
    unique case (state)
      IDLE:  if (cmd_valid) state_nxt = nokey ? RESP : START;
      START: state_nxt = WAIT;
      WAIT:  if (done || tmo) state_nxt = RESP;
      RESP:  if (rsp_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  // Handshake/strobe outputs are decoded from the next state so they are
  // registered yet line up with the state they describe.
  always_ff @(posedge clk) begin
    if (reset) begin
      cmd_ready     <= 1'b1;
      rsp_valid     <= 1'b0;
      aes_en        <= 1'b0;
      rsp_data      <= '0;
      rsp_err       <= 2'b00;
      key_loaded    <= 1'b0;
      aes_ctrl      <= '0;
      aes_key       <= '0;
      aes_plaintext <= '0;
      op            <= 1'b0;
      cnt           <= '0;
    end else begin
      cmd_ready <= (state_nxt == IDLE);
      rsp_valid <= (state_nxt == RESP);
      aes_en    <= (state_nxt == START);

      if (accept) begin
        op <= cmd_op;
        if (!cmd_op) begin
          aes_key    <= cmd_data;
          key_loaded <= 1'b0;
          aes_ctrl   <= `CTRL_KEY;
        end else if (key_loaded) begin
          aes_plaintext <= cmd_data[0:`BLK_S-1];
          aes_ctrl      <= `CTRL_ENCRYPT;
        end else begin
          rsp_err  <= 2'b01;
          rsp_data <= '0;
        end
      end

      if (state == START) cnt <= '0;
      else if (state == WAIT) cnt <= cnt + 16'd1;

      if (done) begin
        if (status_ok) begin
          rsp_err  <= 2'b00;
          rsp_data <= op ? aes_ciphertext : '0;
          if (!op) key_loaded <= 1'b1;
        end else begin
          rsp_err  <= 2'b11;
          rsp_data <= '0;
        end
      end else if (tmo) begin
        rsp_err  <= 2'b10;
        rsp_data <= '0;
      end
    end
  end

endmodule

// File: tb/tb_aes_cmd_seq.sv
// Self-checking bench for aes_cmd_seq: directed vectors plus randomized
// commands, checked against a transaction-level reference model.

`ifndef KEY_S
`define KEY_S 128
`endif
`ifndef BLK_S
`define BLK_S 128
`endif
`ifndef CTRL_S
`define CTRL_S 2
`endif
`ifndef STATUS_S
`define STATUS_S 4
`endif
`ifndef CTRL_KEY
`define CTRL_KEY 2'b01
`endif
`ifndef CTRL_ENCRYPT
`define CTRL_ENCRYPT 2'b10
`endif
`ifndef S_KEY_MASK
`define S_KEY_MASK 4'b0001
`endif
`ifndef S_CIPHER_MASK
`define S_CIPHER_MASK 4'b0010
`endif

module tb_aes_cmd_seq;

  localparam int unsigned TO = 8;
  localparam logic [127:0] FK = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] FP = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] FC = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;

  logic                 clk = 1'b0;
  logic                 reset = 1'b1;
  logic                 cmd_valid = 1'b0;
  logic                 cmd_ready;
  logic                 cmd_op = 1'b0;
  logic [0:`KEY_S-1]    cmd_data = '0;
  logic                 rsp_valid;
  logic                 rsp_ready = 1'b0;
  logic [0:`BLK_S-1]    rsp_data;
  logic [1:0]           rsp_err;
  logic                 key_loaded;
  logic                 aes_en;
  logic [`CTRL_S-1:0]   aes_ctrl;
  logic [0:`KEY_S-1]    aes_key;
  logic [0:`BLK_S-1]    aes_plaintext;
  logic                 aes_en_o = 1'b0;
  logic [`STATUS_S-1:0] aes_status = '0;
  logic [0:`BLK_S-1]    aes_ciphertext = '0;

  int total = 0;
  int bad = 0;

  // reference model state
  logic         kl = 1'b0;
  logic [127:0] m_key = '0;
  logic [127:0] m_pt = '0;

  aes_cmd_seq #(.TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .reset(reset),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op), .cmd_data(cmd_data),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data), .rsp_err(rsp_err),
    .key_loaded(key_loaded), .aes_en(aes_en), .aes_ctrl(aes_ctrl),
    .aes_key(aes_key), .aes_plaintext(aes_plaintext),
    .aes_en_o(aes_en_o), .aes_status(aes_status), .aes_ciphertext(aes_ciphertext)
  );

  always #5 clk = ~clk;

  initial begin
    #1ms;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic [127:0] rnd128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  // Stand-in for the cipher: the known FIPS-197 pair, otherwise an arbitrary
  // mix of key and plaintext that is distinct per operand pair.
  function automatic logic [127:0] ct_of(input logic [127:0] k, input logic [127:0] p);
    if (k == FK && p == FP) return FC;
    return p ^ {k[63:0], k[127:64]} ^ 128'h5a5a_0f0f_3c3c_a5a5_f0f0_c3c3_9696_6969;
  endfunction

  // One command: lat = WAIT cycle on which aes_en_o pulses (0 = never),
  // status = value presented with that pulse, bp = cycles of rsp_ready low.
  task automatic run_cmd(input bit op, input logic [127:0] data, input int lat,
                         input logic [3:0] status, input int bp);
    logic nokey, good, resp_done;
    logic [1:0] e_err;
    logic [127:0] e_data, ct;
    int e_c, got_c, wt;

    nokey = op && !kl;
    if (!op) begin
      m_key = data;
      kl = 1'b0;
    end else if (!nokey) begin
      m_pt = data;
    end
    ct = ct_of(m_key, m_pt);
    good = op ? ((status & `S_CIPHER_MASK) != 0) : ((status & `S_KEY_MASK) != 0);

    if (nokey) begin
      e_err = 2'b01; e_data = '0; e_c = 1;
    end else if (lat >= 1 && lat <= int'(TO)) begin
      e_c = lat + 2;
      if (good) begin
        e_err = 2'b00; e_data = op ? ct : '0;
        if (!op) kl = 1'b1;
      end else begin
        e_err = 2'b11; e_data = '0;
      end
    end else begin
      e_err = 2'b10; e_data = '0; e_c = int'(TO) + 2;
    end

    cmd_valid = 1'b1; cmd_op = op; cmd_data = data;
    wt = 0;
    while (!cmd_ready && wt < 5) begin
      @(negedge clk);
      wt++;
    end
    chk("cmd_ready_idle", cmd_ready, 1'b1);
    if (!cmd_ready) begin
      cmd_valid = 1'b0;
      return;
    end
    @(negedge clk);
    cmd_valid = 1'b0;
    cmd_op = 1'($urandom);
    cmd_data = rnd128();

    got_c = 0;
    resp_done = 1'b0;
    for (int c = 1; c <= 60; c++) begin
      if (c > 1) @(negedge clk);
      chk("aes_en", aes_en, (c == 1 && !nokey));
      if (c == 1 && !nokey) chk("aes_ctrl", aes_ctrl, op ? `CTRL_ENCRYPT : `CTRL_KEY);
      aes_en_o = (lat != 0 && c == lat + 1);
      aes_status = aes_en_o ? status : 4'($urandom);
      aes_ciphertext = aes_en_o ? ct : rnd128();
      if (got_c == 0) begin
        if (!op && !rsp_valid) chk("key_loaded_busy", key_loaded, 1'b0);
        if (rsp_valid) begin
          got_c = c;
          chk("rsp_latency", c, e_c);
          chk("rsp_err", rsp_err, e_err);
          chk("rsp_data", rsp_data, e_data);
          chk("key_loaded", key_loaded, kl);
          chk("aes_key", aes_key, m_key);
          chk("aes_plaintext", aes_plaintext, m_pt);
          rsp_ready = (bp == 0);
        end
      end else if (c <= got_c + bp) begin
        chk("hold_valid", rsp_valid, 1'b1);
        chk("hold_cmd_ready", cmd_ready, 1'b0);
        chk("hold_err", rsp_err, e_err);
        chk("hold_data", rsp_data, e_data);
        if (c == got_c + bp) rsp_ready = 1'b1;
      end else if (c == got_c + bp + 1) begin
        chk("rsp_drop", rsp_valid, 1'b0);
        chk("cmd_ready_back", cmd_ready, 1'b1);
        rsp_ready = 1'b0;
        resp_done = 1'b1;
      end
      if (resp_done && c >= lat + 2) break;
    end
    chk("rsp_done", resp_done, 1'b1);
    aes_en_o = 1'b0;
    rsp_ready = 1'b0;
    chk("key_loaded_after", key_loaded, kl);
  endtask

  initial begin
    int r, lat, bp;
    bit op;
    logic [3:0] st, mask;

    reset = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst_cmd_ready", cmd_ready, 1'b1);
    chk("rst_rsp_valid", rsp_valid, 1'b0);
    chk("rst_rsp_data", rsp_data, '0);
    chk("rst_rsp_err", rsp_err, 2'b00);
    chk("rst_key_loaded", key_loaded, 1'b0);
    chk("rst_aes_en", aes_en, 1'b0);
    chk("rst_aes_ctrl", aes_ctrl, '0);
    chk("rst_aes_key", aes_key, '0);
    chk("rst_aes_pt", aes_plaintext, '0);
    reset = 1'b0;
    @(negedge clk);

    run_cmd(1'b1, FP, 3, `S_CIPHER_MASK, 0);          // encrypt before any key
    run_cmd(1'b0, FK, 4, `S_KEY_MASK, 0);             // FIPS key load
    run_cmd(1'b1, FP, 2, `S_CIPHER_MASK, 10);         // FIPS encrypt, backpressure
    run_cmd(1'b0, rnd128(), 0, `S_KEY_MASK, 1);       // key load timeout
    run_cmd(1'b1, FP, 3, `S_CIPHER_MASK, 0);          // key gone -> NOKEY
    run_cmd(1'b0, FK, int'(TO), `S_KEY_MASK, 0);      // completion on the limit wins
    run_cmd(1'b0, rnd128(), int'(TO) + 3, `S_KEY_MASK, 2); // timeout, late pulse in RESP
    run_cmd(1'b0, FK, 1, `S_KEY_MASK, 0);
    run_cmd(1'b1, FP, 5, 4'b0000, 0);                 // status mismatch
    run_cmd(1'b1, rnd128(), int'(TO) + 2, `S_CIPHER_MASK, 0); // timeout, late pulse in IDLE
    run_cmd(1'b1, FP, 6, `S_CIPHER_MASK | `S_KEY_MASK, 0);

    for (int i = 0; i < 40; i++) begin
      op = ($urandom_range(0, 2) != 0);
      r = $urandom_range(0, 9);
      if (r == 0) lat = 0;
      else if (r == 1) lat = int'(TO) + 1 + $urandom_range(0, 3);
      else lat = $urandom_range(1, TO);
      mask = op ? `S_CIPHER_MASK : `S_KEY_MASK;
      st = 4'($urandom);
      st = ($urandom_range(0, 9) < 7) ? (st | mask) : (st & ~mask);
      bp = $urandom_range(0, 3);
      run_cmd(op, rnd128(), lat, st, bp);
    end

    // reset while an encrypt is in WAIT
    run_cmd(1'b0, FK, 2, `S_KEY_MASK, 0);
    cmd_valid = 1'b1; cmd_op = 1'b1; cmd_data = FP;
    @(negedge clk);
    cmd_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk("wait_key_loaded", key_loaded, 1'b1);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    kl = 1'b0; m_key = '0; m_pt = '0;
    chk("rstw_rsp_valid", rsp_valid, 1'b0);
    chk("rstw_key_loaded", key_loaded, 1'b0);
    chk("rstw_cmd_ready", cmd_ready, 1'b1);
    chk("rstw_aes_en", aes_en, 1'b0);
    chk("rstw_aes_key", aes_key, '0);
    run_cmd(1'b1, FP, 2, `S_CIPHER_MASK, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
